clkdiv_ctrl: RTL and testbench

CLKDIV_CTRL -- requirements
Module: clkdiv_ctrl

---
 rtl/clkdiv_if.sv | 24 ++
 rtl/clkdiv_ctrl.sv | 138 +++++++++++++
 tb/tb_clkdiv_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/clkdiv_if.sv
// Control/status bundle for clkdiv_ctrl: run/config handshake from the master, divider status from the slave.
interface clkdiv_if;
  localparam int unsigned DIV_W = 8;

  logic             run;
  logic             cfg_req;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ack;
  logic             cfg_err;
  logic             busy;
  logic             clk_en;
  logic             clk_out;
  logic [DIV_W-1:0] div_cur;

  modport master (
    output run, cfg_req, cfg_div,
    input  cfg_ack, cfg_err, busy, clk_en, clk_out, div_cur
  );

  modport slave (
    input  run, cfg_req, cfg_div,
    output cfg_ack, cfg_err, busy, clk_en, clk_out, div_cur
  );
endinterface

// File: rtl/clkdiv_ctrl.sv
// Programmable clock divider with glitch-free ratio changes applied at period boundaries.
// Optional feature: define CLKDIV_PERIOD_CNT_EN to add the 16-bit period_cnt output.
module clkdiv_ctrl #(
  parameter int unsigned DIV_RST = 2
) (
  input  logic        clk_50mhz,
  input  logic        rst,
  clkdiv_if.slave     bus
`ifdef CLKDIV_PERIOD_CNT_EN
  ,
  output logic [15:0] period_cnt
`endif
);
  localparam int unsigned DIV_W = 8;

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   pend_q, pend_d;
  logic               seen_q, seen_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               en_q, en_d;
  logic               out_q, out_d;
  logic               req_new, req_ok, wrap, active_d;

  // State and registered outputs
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= DIV_W'(DIV_RST);
      pend_q  <= DIV_W'(DIV_RST);
      seen_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      seen_q  <= seen_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      out_q   <= out_d;
    end
  end

  // Next state; outputs are derived from the next cnt/div so they line up with the registered count
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    pend_d   = pend_q;
    ack_d    = 1'b0;

    // Requests arriving while a change is pending are not sampled and do not set seen
    req_new  = bus.cfg_req && !seen_q && (state_q != PEND);
    req_ok   = (bus.cfg_div >= DIV_W'(2));
    wrap     = (cnt_q == div_q - DIV_W'(1));
    seen_d   = bus.cfg_req && (seen_q || req_new);
    err_d    = req_new && !req_ok;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_new && req_ok) begin
          div_d = bus.cfg_div;
          ack_d = 1'b1;
        end
        if (bus.run) state_d = RUN;
      end
      RUN: begin
        if (!bus.run) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (req_new && req_ok) begin
            div_d = bus.cfg_div;
            ack_d = 1'b1;
          end
        end else begin
          cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
          if (req_new && req_ok) begin
            pend_d  = bus.cfg_div;
            state_d = PEND;
          end
        end
      end
      PEND: begin
        if (!bus.run) begin
          div_d   = pend_q;
          ack_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (wrap) begin
          div_d   = pend_q;
          ack_d   = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    active_d = (state_d != IDLE);
    en_d     = active_d && (cnt_d == div_d - DIV_W'(1));
    out_d    = active_d && (cnt_d < div_d - (div_d >> 1));
    busy_d   = (state_d == PEND);
  end

  assign bus.cfg_ack = ack_q;
  assign bus.cfg_err = err_q;
  assign bus.busy    = busy_q;
  assign bus.clk_en  = en_q;
  assign bus.clk_out = out_q;
  assign bus.div_cur = div_q;

`ifdef CLKDIV_PERIOD_CNT_EN
  // Completed periods since the last ratio change
  always_ff @(posedge clk_50mhz) begin
    if (rst || ack_q) period_cnt <= '0;
    else if (en_q)    period_cnt <= period_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Self-checking bench for clkdiv_ctrl: directed scenarios plus random traffic against a period-level model.
module tb_clkdiv_ctrl;
  localparam int unsigned DIV_RST = 2;

  logic clk_50mhz = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #10 clk_50mhz = ~clk_50mhz;

  clkdiv_if bus();

`ifdef CLKDIV_PERIOD_CNT_EN
  logic [15:0] period_cnt;
`endif

  clkdiv_ctrl #(.DIV_RST(DIV_RST)) dut (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .bus       (bus)
`ifdef CLKDIV_PERIOD_CNT_EN
    ,
    .period_cnt(period_cnt)
`endif
  );

  // Reference model: running flag, position in the current period, ratio, pending ratio
  bit m_running, m_pend_v, m_seen, m_ack, m_err;
  int m_pos, m_n, m_pend, m_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit prev_en, nreq, live;
    if (rst) begin
      m_running = 0; m_pos = 0; m_n = DIV_RST; m_pend = DIV_RST;
      m_pend_v = 0; m_seen = 0; m_ack = 0; m_err = 0; m_pc = 0;
      return;
    end
    prev_en = m_running && (m_pos == m_n - 1);
    if (m_ack) m_pc = 0;
    else if (prev_en) m_pc = (m_pc + 1) % 65536;
    m_ack = 0;
    m_err = 0;
    nreq = bus.cfg_req && !m_seen && !m_pend_v;
    if (!bus.cfg_req) m_seen = 0;
    else if (nreq) m_seen = 1;
    if (m_pend_v) begin
      if (!bus.run) begin
        m_n = m_pend; m_pend_v = 0; m_ack = 1; m_running = 0; m_pos = 0;
      end else if (m_pos == m_n - 1) begin
        m_n = m_pend; m_pend_v = 0; m_ack = 1; m_pos = 0;
      end else begin
        m_pos++;
      end
    end else begin
      live = m_running && bus.run;
      if (nreq && bus.cfg_div < 2) m_err = 1;
      else if (nreq && live) begin m_pend = int'(bus.cfg_div); m_pend_v = 1; end
      else if (nreq) begin m_n = int'(bus.cfg_div); m_ack = 1; end
      if (live) m_pos = (m_pos + 1) % m_n;
      else begin m_pos = 0; m_running = bus.run; end
    end
  endtask

  task automatic compare_all();
    check("clk_out", 32'(bus.clk_out), 32'(m_running && (m_pos < (m_n + 1) / 2)));
    check("clk_en",  32'(bus.clk_en),  32'(m_running && (m_pos == m_n - 1)));
    check("div_cur", 32'(bus.div_cur), 32'(m_n));
    check("busy",    32'(bus.busy),    32'(m_pend_v));
    check("cfg_ack", 32'(bus.cfg_ack), 32'(m_ack));
    check("cfg_err", 32'(bus.cfg_err), 32'(m_err));
`ifdef CLKDIV_PERIOD_CNT_EN
    check("period_cnt", 32'(period_cnt), 32'(m_pc));
`endif
  endtask

  // One clock: model follows the edge, DUT is compared on the falling edge
  task automatic tick();
    @(posedge clk_50mhz);
    model_step();
    @(negedge clk_50mhz);
    compare_all();
  endtask

  // Hold a request until acknowledged or rejected, then release it
  task automatic request(input logic [7:0] div);
    bit done = 0;
    bus.cfg_div = div;
    bus.cfg_req = 1'b1;
    for (int k = 0; k < 300 && !done; k++) begin
      tick();
      done = bus.cfg_ack || bus.cfg_err;
    end
    if (!done) check("req_timeout", 32'(done), 32'd1);
    bus.cfg_req = 1'b0;
    tick();
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    bus.run = 1'b0;
    bus.cfg_req = 1'b0;
    bus.cfg_div = 8'd0;
    @(negedge clk_50mhz);
    tick();
    tick();
    check("rst_div", 32'(bus.div_cur), 32'(DIV_RST));
    check("rst_out", 32'(bus.clk_out), 32'd0);
    rst = 1'b0;

    // Default ratio 2 toggles every cycle
    bus.run = 1'b1;
    tick();
    check("n2_first_high", 32'(bus.clk_out), 32'd1);
    repeat (8) tick();

    // Load 5 in IDLE, then run
    bus.run = 1'b0;
    tick();
    check("stop_out", 32'(bus.clk_out), 32'd0);
    request(8'd5);
    check("div5", 32'(bus.div_cur), 32'd5);
    bus.run = 1'b1;
    repeat (15) tick();

    // Running at 4, change to 6 requested while cnt=1
    bus.run = 1'b0;
    tick();
    request(8'd4);
    bus.run = 1'b1;
    found = 0;
    for (int k = 0; k < 12 && !found; k++) begin
      tick();
      found = (m_pos == 1);
    end
    check("reach_cnt1", 32'(found), 32'd1);
    bus.cfg_div = 8'd6;
    bus.cfg_req = 1'b1;
    tick();
    check("busy_pend", 32'(bus.busy), 32'd1);
    request(8'd6);
    repeat (14) tick();
    check("div6", 32'(bus.div_cur), 32'd6);

    // Illegal ratios and a long-held illegal request
    request(8'd0);
    request(8'd1);
    bus.cfg_div = 8'd0;
    bus.cfg_req = 1'b1;
    repeat (10) tick();
    bus.cfg_req = 1'b0;
    tick();
    check("div_kept", 32'(bus.div_cur), 32'd6);

    // Pending change applied by stopping
    bus.cfg_div = 8'd3;
    bus.cfg_req = 1'b1;
    tick();
    bus.run = 1'b0;
    tick();
    check("stop_ack", 32'(bus.cfg_ack), 32'd1);
    check("stop_div", 32'(bus.div_cur), 32'd3);
    bus.cfg_req = 1'b0;
    tick();

    // Reset while pending discards the change
    bus.run = 1'b1;
    repeat (2) tick();
    bus.cfg_div = 8'd8;
    bus.cfg_req = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    check("rst_pend_ack", 32'(bus.cfg_ack), 32'd0);
    check("rst_pend_div", 32'(bus.div_cur), 32'(DIV_RST));
    rst = 1'b0;
    bus.cfg_req = 1'b0;
    tick();

`ifdef CLKDIV_PERIOD_CNT_EN
    repeat (600) tick();
    request(8'd3);
    check("pc_clear", 32'(period_cnt), 32'd0);
`endif

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) bus.run = ~bus.run;
      if (bus.cfg_req) begin
        if (bus.cfg_ack || bus.cfg_err || $urandom_range(0, 29) == 0) bus.cfg_req = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        bus.cfg_div = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
        bus.cfg_req = 1'b1;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
